// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset PC and opcode field definitions
package cpu_pkg;

    localparam int          CPU_AW       = 32;
    localparam int          CPU_IW       = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam int          CPU_PC_STEP  = 4;

    localparam int OP_MSB = 2;
    localparam int OP_LSB = 0;

    typedef enum logic [2:0] {
        OP_R = 3'b000,
        OP_I = 3'b001,
        OP_L = 3'b010,
        OP_S = 3'b011,
        OP_B = 3'b100,
        OP_J = 3'b101,
        OP_F = 3'b110
    } opcode_t;

    function automatic opcode_t op_field(input logic [CPU_IW-1:0] instr);
        return opcode_t'(instr[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular buffer of fetched {instr, pc} words with flush
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [W-1:0]  hold;
    logic          full;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;

    // DEPTH is a power of two, so pointers wrap naturally at PW bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (do_pop)
                rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wptr] <= push_data;
    end

    // Keeps the last presented head visible once the queue drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold <= '0;
        else if (!empty)
            hold <= mem[rptr];
    end

    assign head = empty ? hold : mem[rptr];

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, credit-gated imem reads, queued hand-off to ID
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int             AW       = CPU_AW,
    parameter int             IW       = CPU_IW,
    parameter int             DEPTH    = 2,
    parameter logic [AW-1:0]  RESET_PC = CPU_RESET_PC,
    parameter int             PC_STEP  = CPU_PC_STEP
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    pc_q;
    logic             inflight_q;
    logic [AW-1:0]    inflight_pc_q;
    logic [CW-1:0]    count;
    logic             empty;
    logic             pop;
    logic             push;
    logic [CW:0]      occ;
    logic [IW+AW-1:0] head;

    assign id_valid = !empty;
    assign pop      = id_valid && id_ready;
    assign push     = inflight_q && !redirect;

    // Slots that will be claimed after this edge; pop implies count >= 1
    assign occ      = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign imem_req = rst_n && !redirect && (occ < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + AW'(PC_STEP);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (IW + AW)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_rdata, inflight_pc_q}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .empty     (empty),
        .head      (head)
    );

    assign id_instr = head[IW+AW-1:AW];
    assign id_pc    = head[AW-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized fetch_unit bench against a queue-level model
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect(1'b0), .redirect_pc(32'h0),
        .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_instr), .id_pc(w_pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    logic [31:0] next_rdata;
    logic [31:0] w_next;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl    = 1'b0;
        m_infl_pc = '0;
        m_pc      = 32'h0;
    endtask

    // Expected outputs come from the queue model; then the model advances one cycle
    task automatic compare_update();
        bit ev;
        bit pop;
        bit er;
        int occ;
        ev  = (mq.size() != 0);
        pop = ev && id_ready;
        occ = mq.size() + int'(m_infl) - int'(pop);
        er  = !redirect && (occ < DEPTH);
        if (!rst_n) begin
            er = 1'b0;
            ev = 1'b0;
        end
        check("imem_req", {31'b0, imem_req}, {31'b0, er});
        if (er)
            check("imem_addr", imem_addr, m_pc);
        check("id_valid", {31'b0, id_valid}, {31'b0, ev});
        if (ev) begin
            check("id_instr", id_instr, mq[0].instr);
            check("id_pc", id_pc, mq[0].pc);
        end
        next_rdata = imem_req ? word_of(imem_addr) : $urandom();
        w_next     = w_req ? word_of(w_addr) : $urandom();
        if (rst_n) begin
            if (pop)
                void'(mq.pop_front());
            if (redirect) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc;
            end else begin
                if (m_infl)
                    mq.push_back('{instr: word_of(m_infl_pc), pc: m_infl_pc});
                m_infl    = er;
                m_infl_pc = m_pc;
                if (er)
                    m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input bit rstv, input bit rdy, input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        rst_n       = rstv;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rdata  = next_rdata;
        w_rdata     = w_next;
        #1;
        compare_update();
        if (!rstv)
            model_reset();
    endtask

    initial begin
        rst_n = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_rdata = '0; w_rdata = '0; next_rdata = '0; w_next = '0;
        model_reset();

        step(0, 0, 0, 0);
        check("reset id_instr", id_instr, 32'h0);
        check("reset id_pc", id_pc, 32'h0);
        check("reset wrap req", {31'b0, w_req}, 32'h0);
        step(0, 0, 0, 0);

        // sequential fetch from reset with ID always ready
        for (int c = 0; c < 8; c++) begin
            step(1, 1, 0, 0);
            if (c == 0) begin
                check("first req", {31'b0, imem_req}, 32'h1);
                check("first addr", imem_addr, 32'h0);
                check("wrap first addr", w_addr, 32'hFFFF_FFFC);
            end
            if (c == 1) begin
                check("valid cycle1", {31'b0, id_valid}, 32'h0);
                check("wrap second addr", w_addr, 32'h0);
            end
            if (c == 2) begin
                check("valid cycle2", {31'b0, id_valid}, 32'h1);
                check("pc cycle2", id_pc, 32'h0);
                check("wrap pc cycle2", w_pc, 32'hFFFF_FFFC);
                check("wrap instr cycle2", w_instr, 32'hFFFC_FFFF ^ 32'h5A5A_C3C3);
            end
            if (c == 3) begin
                check("pc cycle3", id_pc, 32'h4);
                check("wrap pc cycle3", w_pc, 32'h0);
            end
            if (c == 4)
                check("pc cycle4", id_pc, 32'h8);
        end

        // stall until the credit rule blocks requests, then release
        for (int c = 0; c < 6; c++) begin
            step(1, 0, 0, 0);
            if (c == 5) begin
                check("stall req off", {31'b0, imem_req}, 32'h0);
                check("stall valid", {31'b0, id_valid}, 32'h1);
            end
        end
        for (int c = 0; c < 4; c++)
            step(1, 1, 0, 0);

        // redirect while a read is in flight
        step(1, 1, 1, 32'h100);
        check("redirect cycle no req", {31'b0, imem_req}, 32'h0);
        step(1, 1, 0, 0);
        check("post redirect addr", imem_addr, 32'h100);
        check("post redirect valid", {31'b0, id_valid}, 32'h0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("redirect target pc", id_pc, 32'h100);
        for (int c = 0; c < 3; c++)
            step(1, 1, 0, 0);

        // redirect while stalled with a full queue
        for (int c = 0; c < 5; c++)
            step(1, 0, 0, 0);
        step(1, 0, 1, 32'h100);
        step(1, 0, 0, 0);
        check("flush during stall", {31'b0, id_valid}, 32'h0);
        for (int c = 0; c < 5; c++)
            step(1, 1, 0, 0);

        // asynchronous reset while the queue holds two entries
        for (int c = 0; c < 5; c++)
            step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("async reset valid", {31'b0, id_valid}, 32'h0);
        check("async reset req", {31'b0, imem_req}, 32'h0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("refetch addr", imem_addr, 32'h0);

        // randomized traffic with bursty stalls, redirects and occasional resets
        for (int c = 0; c < 3000; c++) begin
            bit          rdy;
            bit          redir;
            bit          rstv;
            logic [31:0] rpc;
            rdy   = ((c / 40) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            rstv  = ($urandom_range(0, 499) != 0);
            step(rstv, rdy, redir, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
